// File: rtl/hud_pkg.sv
// hud_pkg: shared RGB444 colours and coordinate/pixel types for the HUD overlays
package hud_pkg;
   typedef logic [10:0] coord_t;
   typedef logic [11:0] pixel_t;
   localparam pixel_t RED    = 12'hF00;
   localparam pixel_t GREEN  = 12'h0F0;
   localparam pixel_t BLUE   = 12'h00F;
   localparam pixel_t WHITE  = 12'hFFF;
   localparam pixel_t BLACK  = 12'h000;
   localparam pixel_t YELLOW = 12'hFF0;
endpackage

// File: rtl/hud_bar_level.sv
// hud_bar_level: per-bar target clamp, slewed displayed level and registered low flag
module hud_bar_level #(
   parameter int VAL_W      = 6,
   parameter int MAX_SEG    = 18,
   parameter int LOW_THRESH = 3,
   parameter bit SLEW_EN    = 1'b1,
   parameter int LVL_W      = $clog2(MAX_SEG + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_start,
   input  logic             enable,
   input  logic [VAL_W-1:0] value,
   output logic [LVL_W-1:0] shown,
   output logic             low
);
   logic [LVL_W-1:0] tgt, shown_d, shown_q;
   logic             low_d, low_q;
   always_comb begin
      tgt     = (int'(value) > MAX_SEG) ? LVL_W'(MAX_SEG) : LVL_W'(value);
      shown_d = !enable ? '0 :
                !SLEW_EN ? tgt :
                !frame_start ? shown_q :
                (shown_q < tgt) ? shown_q + LVL_W'(1) :
                (shown_q > tgt) ? shown_q - LVL_W'(1) : shown_q;
      low_d   = enable && shown_q != '0 && int'(shown_q) <= LOW_THRESH;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         shown_q <= '0;
         low_q   <= 1'b0;
      end else begin
         shown_q <= shown_d;
         low_q   <= low_d;
      end
   end
   assign shown = shown_q;
   assign low   = low_q;
endmodule

// File: rtl/hud_bar_gauge.sv
// hud_bar_gauge: N segmented HUD bars with slew animation, low blink and a 2-stage pixel pipeline
module hud_bar_gauge import hud_pkg::*; #(
   parameter int     N_BARS       = 2,
   parameter int     VAL_W        = 6,
   parameter int     MAX_SEG      = 18,
   parameter int     SEG_W_LOG2   = 4,
   parameter int     X0           = 320,
   parameter int     Y0           = 55,
   parameter int     BAR_H        = 11,
   parameter int     BAR_PITCH    = 20,
   parameter int     LOW_THRESH   = 3,
   parameter int     BLINK_FRAMES = 32,
   parameter bit     SLEW_EN      = 1'b1,
   parameter pixel_t FILL_COLOR   = RED,
   parameter pixel_t LOW_COLOR    = YELLOW,
   parameter pixel_t BORDER_COLOR = WHITE
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    frame_start,
   input  logic [N_BARS-1:0]       bar_enable,
   input  logic [N_BARS*VAL_W-1:0] bar_value,
   input  logic [10:0]             VGA_xpos,
   input  logic [10:0]             VGA_ypos,
   output logic [11:0]             VGA_data,
   output logic [N_BARS-1:0]       low_flag
);
   localparam int     LVL_W = $clog2(MAX_SEG + 1);
   localparam int     CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam coord_t XS    = coord_t'(X0);
   localparam coord_t XE    = coord_t'(X0 + (MAX_SEG << SEG_W_LOG2));
   logic [LVL_W-1:0] shown [N_BARS];
   for (genvar i = 0; i < N_BARS; i++) begin : g_bar
      hud_bar_level #(
         .VAL_W(VAL_W), .MAX_SEG(MAX_SEG), .LOW_THRESH(LOW_THRESH), .SLEW_EN(SLEW_EN), .LVL_W(LVL_W)
      ) u_lvl (
         .clk(clk), .rst(rst), .frame_start(frame_start), .enable(bar_enable[i]),
         .value(bar_value[i*VAL_W +: VAL_W]), .shown(shown[i]), .low(low_flag[i])
      );
   end
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             s1_hit_d, s1_hit_q, s1_low_d, s1_low_q, s1_blink_d, s1_blink_q, s1_edge_d, s1_edge_q;
   logic [LVL_W-1:0] s1_lvl_d, s1_lvl_q;
   coord_t           s1_rel_d, s1_rel_q, y_top, y_bot, lim;
   pixel_t           pix_d, pix_q;
   logic             fill, sep;
   // Stage 1 snapshots the level and blink phase so a pixel sampled on frame_start keeps old values
   always_comb begin
      cnt_d      = !frame_start ? cnt_q : (int'(cnt_q) == BLINK_FRAMES - 1) ? '0 : cnt_q + CNT_W'(1);
      s1_hit_d   = 1'b0;
      s1_lvl_d   = '0;
      s1_low_d   = 1'b0;
      s1_edge_d  = 1'b0;
      s1_blink_d = int'(cnt_q) < BLINK_FRAMES / 2;
      s1_rel_d   = VGA_xpos - XS;
      y_top      = '0;
      y_bot      = '0;
      for (int b = N_BARS - 1; b >= 0; b--) begin
         y_top = coord_t'(Y0 + b * BAR_PITCH);
         y_bot = coord_t'(Y0 + b * BAR_PITCH + BAR_H - 1);
         if (bar_enable[b] && VGA_xpos >= XS && VGA_xpos <= XE && VGA_ypos >= y_top && VGA_ypos <= y_bot) begin
            s1_hit_d  = 1'b1;
            s1_lvl_d  = shown[b];
            s1_low_d  = shown[b] != '0 && int'(shown[b]) <= LOW_THRESH;
            s1_edge_d = VGA_xpos == XS || VGA_xpos == XE || VGA_ypos == y_top || VGA_ypos == y_bot;
         end
      end
      lim   = coord_t'(s1_lvl_q) << SEG_W_LOG2;
      fill  = s1_hit_q && s1_lvl_q != '0 && s1_rel_q <= lim;
      sep   = fill && s1_rel_q[SEG_W_LOG2-1:0] == '0 && s1_rel_q != '0 && s1_rel_q < lim;
      pix_d = (!s1_hit_q || sep) ? BLACK :
              (fill && !(s1_low_q && !s1_blink_q)) ? (s1_low_q ? LOW_COLOR : FILL_COLOR) :
              s1_edge_q ? BORDER_COLOR : BLACK;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         s1_hit_q   <= 1'b0;
         s1_lvl_q   <= '0;
         s1_low_q   <= 1'b0;
         s1_blink_q <= 1'b0;
         s1_edge_q  <= 1'b0;
         s1_rel_q   <= '0;
         pix_q      <= '0;
      end else begin
         cnt_q      <= cnt_d;
         s1_hit_q   <= s1_hit_d;
         s1_lvl_q   <= s1_lvl_d;
         s1_low_q   <= s1_low_d;
         s1_blink_q <= s1_blink_d;
         s1_edge_q  <= s1_edge_d;
         s1_rel_q   <= s1_rel_d;
         pix_q      <= pix_d;
      end
   end
   assign VGA_data = pix_q;
endmodule
